rv_writeback_stage: RTL and testbench

- MEM/WB pipeline register plus write-back logic for the RV32I core; sits directly upstream of the register file.
- Captures MEM-stage results, aligns and extends load data, and selects the write-back source.
- Drives the register file write port (RegWrite, Write_register, Write_data) and maintains a 64-bit retired-instruction counter.
- Write_data also serves as the WB-stage forwarding value.

---
 rtl/rv_writeback_stage.sv | 156 +++++++++++++++
 tb/tb_rv_writeback_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_writeback_stage.sv
// MEM/WB pipeline register and write-back logic for the RV32I core.
// Aligns and extends load data, selects the write-back source and counts retired instructions.
module rv_writeback_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic [1:0]       mem_wb_sel,
  input  logic [2:0]       mem_funct3,
  input  logic [WIDTH-1:0] mem_alu_result,
  input  logic [WIDTH-1:0] mem_load_word,
  input  logic [WIDTH-1:0] mem_pc_plus4,
  input  logic [WIDTH-1:0] mem_imm,
  output logic             RegWrite,
  output logic [4:0]       Write_register,
  output logic [WIDTH-1:0] Write_data,
  output logic             wb_valid,
  output logic             load_fault,
  output logic [63:0]      instret
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic             wb_valid_q;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic [1:0]       wb_sel;
  logic [2:0]       wb_funct3;
  logic [WIDTH-1:0] wb_alu_result;
  logic [WIDTH-1:0] wb_load_word;
  logic [WIDTH-1:0] wb_pc_plus4;
  logic [WIDTH-1:0] wb_imm;
  logic             retired;
  logic [63:0]      instret_q;

  logic [1:0]       offset;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] ld_data;
  logic             align_fault;
  logic             fault;
  logic             commit;

  // retired marks an instruction already written/counted while it is held by a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q    <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_sel        <= '0;
      wb_funct3     <= '0;
      wb_alu_result <= '0;
      wb_load_word  <= '0;
      wb_pc_plus4   <= '0;
      wb_imm        <= '0;
      retired       <= 1'b0;
      instret_q     <= '0;
    end else begin
      if (commit) begin
        instret_q <= instret_q + 64'd1;
      end
      if (flush) begin
        wb_valid_q <= 1'b0;
        retired    <= 1'b0;
      end else if (stall) begin
        if (wb_valid_q && !retired) begin
          retired <= 1'b1;
        end
      end else begin
        wb_valid_q    <= mem_valid;
        wb_reg_write  <= mem_reg_write;
        wb_rd         <= mem_rd;
        wb_sel        <= mem_wb_sel;
        wb_funct3     <= mem_funct3;
        wb_alu_result <= mem_alu_result;
        wb_load_word  <= mem_load_word;
        wb_pc_plus4   <= mem_pc_plus4;
        wb_imm        <= mem_imm;
        retired       <= 1'b0;
      end
    end
  end

  always_comb begin
    offset  = wb_alu_result[1:0];
    ld_byte = 8'h00;
    case (offset)
      2'd0: ld_byte = wb_load_word[7:0];
      2'd1: ld_byte = wb_load_word[15:8];
      2'd2: ld_byte = wb_load_word[23:16];
      2'd3: ld_byte = wb_load_word[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = offset[1] ? wb_load_word[31:16] : wb_load_word[15:0];
  end

  always_comb begin
    ld_data     = '0;
    align_fault = 1'b0;
    case (wb_funct3)
      F3_LB:  ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_LBU: ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
      F3_LH: begin
        ld_data     = {{(WIDTH-16){ld_half[15]}}, ld_half};
        align_fault = offset[0];
      end
      F3_LHU: begin
        ld_data     = {{(WIDTH-16){1'b0}}, ld_half};
        align_fault = offset[0];
      end
      F3_LW: begin
        ld_data     = wb_load_word;
        align_fault = (offset != 2'd0);
      end
      default: align_fault = 1'b1;
    endcase
  end

  // only loads can fault; a faulting load neither writes nor retires
  assign fault  = wb_valid_q && (wb_sel == SEL_LOAD) && align_fault;
  assign commit = wb_valid_q && !retired && !fault;

  always_comb begin
    Write_data = '0;
    if (wb_valid_q) begin
      case (wb_sel)
        SEL_ALU:  Write_data = wb_alu_result;
        SEL_LOAD: Write_data = fault ? '0 : ld_data;
        SEL_PC4:  Write_data = wb_pc_plus4;
        SEL_IMM:  Write_data = wb_imm;
        default:  Write_data = '0;
      endcase
    end
  end

  assign Write_register = wb_valid_q ? wb_rd : 5'd0;
  assign RegWrite       = commit && wb_reg_write && (wb_rd != 5'd0);
  assign wb_valid       = wb_valid_q;
  assign load_fault     = fault;
  assign instret        = instret_q;

endmodule

// File: tb/tb_rv_writeback_stage.sv
// Directed, table-driven bench for rv_writeback_stage plus stall/flush/reset sequences.
module tb_rv_writeback_stage;

  typedef struct {
    string       name;
    logic        valid;
    logic        regw;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] word;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic        expRegWrite;
    logic [4:0]  expReg;
    logic [31:0] expData;
    logic        expFault;
    logic        expCount;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_valid, mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_load_word, mem_pc_plus4, mem_imm;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic        wb_valid, load_fault;
  logic [63:0] instret;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] expInstret = 64'd0;
  vec_t        vecs[$];

  rv_writeback_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
    .mem_alu_result(mem_alu_result), .mem_load_word(mem_load_word),
    .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .wb_valid(wb_valid), .load_fault(load_fault), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic rw, input logic [4:0] rd,
                               input logic [1:0] sel, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [31:0] word,
                               input logic [31:0] pc4, input logic [31:0] imm);
    mem_valid      = v;
    mem_reg_write  = rw;
    mem_rd         = rd;
    mem_wb_sel     = sel;
    mem_funct3     = f3;
    mem_alu_result = alu;
    mem_load_word  = word;
    mem_pc_plus4   = pc4;
    mem_imm        = imm;
  endtask

  task automatic applyBubble();
    applyStimulus(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic addVec(input string n, input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [31:0] word, input logic [31:0] pc4, input logic [31:0] imm,
                        input logic eRw, input logic [4:0] eReg, input logic [31:0] eData,
                        input logic eFault, input logic eCount);
    vec_t t;
    t.name = n; t.valid = v; t.regw = rw; t.rd = rd; t.sel = sel; t.f3 = f3;
    t.alu = alu; t.word = word; t.pc4 = pc4; t.imm = imm;
    t.expRegWrite = eRw; t.expReg = eReg; t.expData = eData;
    t.expFault = eFault; t.expCount = eCount;
    vecs.push_back(t);
  endtask

  initial begin
    addVec("alu_rd5",  1, 1, 5'd5,  2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 1, 5'd5,  32'h0000_1234, 0, 1);
    addVec("lb_off3",  1, 1, 5'd6,  2'b01, 3'b000, 32'h0000_2003, 32'h80FF_7F01, 32'h0, 32'h0, 1, 5'd6, 32'hFFFF_FF80, 0, 1);
    addVec("lbu_off1", 1, 1, 5'd6,  2'b01, 3'b100, 32'h0000_2001, 32'h80FF_7F01, 32'h0, 32'h0, 1, 5'd6, 32'h0000_007F, 0, 1);
    addVec("lh_off2",  1, 1, 5'd6,  2'b01, 3'b001, 32'h0000_2002, 32'h80FF_7F01, 32'h0, 32'h0, 1, 5'd6, 32'hFFFF_80FF, 0, 1);
    addVec("lhu_off0", 1, 1, 5'd6,  2'b01, 3'b101, 32'h0000_2000, 32'h80FF_7F01, 32'h0, 32'h0, 1, 5'd6, 32'h0000_7F01, 0, 1);
    addVec("lbu_off2", 1, 1, 5'd6,  2'b01, 3'b100, 32'h0000_2002, 32'h80FF_7F01, 32'h0, 32'h0, 1, 5'd6, 32'h0000_00FF, 0, 1);
    addVec("lw_ok",    1, 1, 5'd7,  2'b01, 3'b010, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 32'h0, 1, 5'd7, 32'h80FF_7F01, 0, 1);
    addVec("lw_misal", 1, 1, 5'd7,  2'b01, 3'b010, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 32'h0, 0, 5'd7, 32'h0, 1, 0);
    addVec("lh_odd",   1, 1, 5'd7,  2'b01, 3'b001, 32'h0000_1001, 32'h80FF_7F01, 32'h0, 32'h0, 0, 5'd7, 32'h0, 1, 0);
    addVec("f3_011",   1, 1, 5'd7,  2'b01, 3'b011, 32'h0000_1000, 32'h80FF_7F01, 32'h0, 32'h0, 0, 5'd7, 32'h0, 1, 0);
    addVec("alu_x0",   1, 1, 5'd0,  2'b00, 3'b000, 32'h0000_0055, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0000_0055, 0, 1);
    addVec("pc4_rd31", 1, 1, 5'd31, 2'b10, 3'b000, 32'h0000_0010, 32'h0, 32'h0000_0200, 32'h0, 1, 5'd31, 32'h0000_0200, 0, 1);
    addVec("lui_rd9",  1, 1, 5'd9,  2'b11, 3'b000, 32'h0000_0010, 32'h0, 32'h0, 32'h1234_5000, 1, 5'd9, 32'h1234_5000, 0, 1);
    addVec("store",    1, 0, 5'd3,  2'b00, 3'b000, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 0, 5'd3, 32'h0000_0010, 0, 1);
    addVec("invalid",  0, 1, 5'd5,  2'b00, 3'b000, 32'h0000_DEAD, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    addVec("lb_pos",   1, 1, 5'd12, 2'b01, 3'b000, 32'h0000_3000, 32'h0000_00A5, 32'h0, 32'h0, 1, 5'd12, 32'hFFFF_FFA5, 0, 1);

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    applyBubble();
    tick();
    tick();
    checkOutput("reset_RegWrite", RegWrite, 1'b0);
    checkOutput("reset_Write_register", Write_register, 5'd0);
    checkOutput("reset_Write_data", Write_data, 32'h0);
    checkOutput("reset_wb_valid", wb_valid, 1'b0);
    checkOutput("reset_load_fault", load_fault, 1'b0);
    checkOutput("reset_instret", instret, 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].regw, vecs[i].rd, vecs[i].sel, vecs[i].f3,
                    vecs[i].alu, vecs[i].word, vecs[i].pc4, vecs[i].imm);
      tick();
      checkOutput({vecs[i].name, "_RegWrite"}, RegWrite, vecs[i].expRegWrite);
      checkOutput({vecs[i].name, "_Write_register"}, Write_register, vecs[i].expReg);
      checkOutput({vecs[i].name, "_Write_data"}, Write_data, vecs[i].expData);
      checkOutput({vecs[i].name, "_load_fault"}, load_fault, vecs[i].expFault);
      checkOutput({vecs[i].name, "_instret_before"}, instret, expInstret);
      applyBubble();
      tick();
      if (vecs[i].expCount) expInstret = expInstret + 64'd1;
      checkOutput({vecs[i].name, "_instret_after"}, instret, expInstret);
    end

    // JAL held for three stall cycles: one write, one count
    applyStimulus(1, 1, 5'd1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_0104, 32'h0);
    tick();
    checkOutput("jal_RegWrite_first", RegWrite, 1'b1);
    checkOutput("jal_Write_data_first", Write_data, 32'h0000_0104);
    stall = 1'b1;
    applyStimulus(1, 1, 5'd2, 2'b00, 3'b000, 32'hBAD0_BAD0, 32'h0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 0) expInstret = expInstret + 64'd1;
      checkOutput($sformatf("jal_stall%0d_RegWrite", c), RegWrite, 1'b0);
      checkOutput($sformatf("jal_stall%0d_Write_register", c), Write_register, 5'd1);
      checkOutput($sformatf("jal_stall%0d_Write_data", c), Write_data, 32'h0000_0104);
      checkOutput($sformatf("jal_stall%0d_instret", c), instret, expInstret);
    end
    stall = 1'b0;
    applyBubble();
    tick();
    checkOutput("jal_release_wb_valid", wb_valid, 1'b0);
    checkOutput("jal_release_instret", instret, expInstret);

    // flush wins over stall
    applyStimulus(1, 1, 5'd4, 2'b00, 3'b000, 32'h0000_00AA, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("flush_pre_RegWrite", RegWrite, 1'b1);
    stall = 1'b1; flush = 1'b1;
    tick();
    expInstret = expInstret + 64'd1;
    checkOutput("flush_wb_valid", wb_valid, 1'b0);
    checkOutput("flush_RegWrite", RegWrite, 1'b0);
    checkOutput("flush_Write_data", Write_data, 32'h0);
    checkOutput("flush_instret", instret, expInstret);
    stall = 1'b0; flush = 1'b0;
    applyBubble();
    tick();

    // reset while a valid instruction is held
    applyStimulus(1, 1, 5'd8, 2'b00, 3'b000, 32'h0000_0077, 32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("rststall_pre_RegWrite", RegWrite, 1'b1);
    stall = 1'b1;
    tick();
    expInstret = expInstret + 64'd1;
    checkOutput("rststall_held_RegWrite", RegWrite, 1'b0);
    checkOutput("rststall_held_instret", instret, expInstret);
    rst = 1'b1;
    tick();
    expInstret = 64'd0;
    checkOutput("rststall_RegWrite", RegWrite, 1'b0);
    checkOutput("rststall_Write_register", Write_register, 5'd0);
    checkOutput("rststall_Write_data", Write_data, 32'h0);
    checkOutput("rststall_wb_valid", wb_valid, 1'b0);
    checkOutput("rststall_instret", instret, expInstret);
    rst = 1'b0;
    tick();
    checkOutput("rststall_after_RegWrite", RegWrite, 1'b0);
    checkOutput("rststall_after_instret", instret, expInstret);
    stall = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
